// File: rtl/tl_dma_master_arbiter.sv
// rtl/tl_dma_master_arbiter.sv - merges per-channel DMA TL-UL master ports onto one TL-UL master port
//
// Purpose:
//   Round-robin arbitration of NoC DMA A-channel requests onto a single TL-UL
//   master port. The winning channel index is carried in m_a_source, and D
//   responses are routed back to the channel named by m_d_source. Each channel
//   is limited to MAX_OUT outstanding requests.
//
// Ports:
//   i_dma_clock, i_dma_reset      clock, synchronous active-high reset
//   i_sa_* / o_sa_ready           per-channel A requests (slice i = channel i)
//   o_sd_* / i_sd_ready           per-channel D responses (fields broadcast, valid per channel)
//   o_m_a_* / i_m_a_ready         merged A channel toward the interconnect
//   i_m_d_* / o_m_d_ready         merged D channel from the interconnect
//   o_bad_src                     pulse: a D beat with an out-of-range source was dropped

module tl_dma_master_arbiter #(
  parameter int NoC     = 2,
  parameter int TL_RS   = 4,
  parameter int MAX_OUT = 1
) (
  input  logic                 i_dma_clock,
  input  logic                 i_dma_reset,
  // per-channel A
  input  logic [3*NoC-1:0]     i_sa_opcode,
  input  logic [3*NoC-1:0]     i_sa_param,
  input  logic [4*NoC-1:0]     i_sa_size,
  input  logic [32*NoC-1:0]    i_sa_address,
  input  logic [32*NoC-1:0]    i_sa_data,
  input  logic [4*NoC-1:0]     i_sa_mask,
  input  logic [NoC-1:0]       i_sa_corrupt,
  input  logic [NoC-1:0]       i_sa_valid,
  output logic [NoC-1:0]       o_sa_ready,
  // per-channel D
  output logic [3*NoC-1:0]     o_sd_opcode,
  output logic [2*NoC-1:0]     o_sd_param,
  output logic [4*NoC-1:0]     o_sd_size,
  output logic [32*NoC-1:0]    o_sd_data,
  output logic [NoC-1:0]       o_sd_denied,
  output logic [NoC-1:0]       o_sd_corrupt,
  output logic [NoC-1:0]       o_sd_valid,
  input  logic [NoC-1:0]       i_sd_ready,
  // merged A
  output logic [2:0]           o_m_a_opcode,
  output logic [2:0]           o_m_a_param,
  output logic [3:0]           o_m_a_size,
  output logic [TL_RS-1:0]     o_m_a_source,
  output logic [31:0]          o_m_a_address,
  output logic [31:0]          o_m_a_data,
  output logic [3:0]           o_m_a_mask,
  output logic                 o_m_a_corrupt,
  output logic                 o_m_a_valid,
  input  logic                 i_m_a_ready,
  // merged D
  input  logic [2:0]           i_m_d_opcode,
  input  logic [1:0]           i_m_d_param,
  input  logic [3:0]           i_m_d_size,
  input  logic [TL_RS-1:0]     i_m_d_source,
  input  logic [31:0]          i_m_d_data,
  input  logic                 i_m_d_denied,
  input  logic                 i_m_d_corrupt,
  input  logic                 i_m_d_valid,
  output logic                 o_m_d_ready,
  output logic                 o_bad_src
);

  localparam int PW = (NoC > 1) ? $clog2(NoC) : 1;

  logic [PW-1:0] r_rr_ptr;
  logic          r_lock;
  logic [PW-1:0] r_lock_idx;
  logic [3:0]    r_out_cnt [NoC];

  logic [NoC-1:0] w_elig;
  logic           w_any_elig;
  logic [PW-1:0]  w_scan_grant;
  logic [PW-1:0]  w_grant;
  logic [PW-1:0]  w_rr_next;
  logic           w_a_hs;
  logic           w_d_hit;
  logic           w_d_hs;
  logic           w_m_d_ready_raw;
  int             w_best_dist;
  int             w_dist;

  always_comb begin
    for (int i = 0; i < NoC; i++) begin
      w_elig[i] = i_sa_valid[i] && (r_out_cnt[i] < 4'(MAX_OUT));
    end
  end

  assign w_any_elig = |w_elig;

  // Round-robin pick: the eligible channel closest to r_rr_ptr going upward
  // (with wrap) wins.
  always_comb begin
    w_scan_grant = '0;
    w_best_dist  = NoC;
    w_dist       = 0;
    for (int i = 0; i < NoC; i++) begin
      w_dist = i - int'(r_rr_ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + NoC;
      end
      if (w_elig[i] && (w_dist < w_best_dist)) begin
        w_best_dist  = w_dist;
        w_scan_grant = PW'(i);
      end
    end
  end

  // A stalled request keeps its grant so the presented beat cannot change
  // under the interconnect before it is accepted.
  assign w_grant     = r_lock ? r_lock_idx : w_scan_grant;
  assign o_m_a_valid = !i_dma_reset && (r_lock || w_any_elig);
  assign w_a_hs      = o_m_a_valid && i_m_a_ready;
  assign w_rr_next   = (int'(w_grant) == NoC - 1) ? '0 : w_grant + 1'b1;
  assign o_m_a_source = TL_RS'(w_grant);

  always_comb begin
    o_m_a_opcode  = '0;
    o_m_a_param   = '0;
    o_m_a_size    = '0;
    o_m_a_address = '0;
    o_m_a_data    = '0;
    o_m_a_mask    = '0;
    o_m_a_corrupt = 1'b0;
    o_sa_ready    = '0;
    for (int i = 0; i < NoC; i++) begin
      if (int'(w_grant) == i) begin
        o_m_a_opcode  = i_sa_opcode[3*i +: 3];
        o_m_a_param   = i_sa_param[3*i +: 3];
        o_m_a_size    = i_sa_size[4*i +: 4];
        o_m_a_address = i_sa_address[32*i +: 32];
        o_m_a_data    = i_sa_data[32*i +: 32];
        o_m_a_mask    = i_sa_mask[4*i +: 4];
        o_m_a_corrupt = i_sa_corrupt[i];
        o_sa_ready[i] = o_m_a_valid && i_m_a_ready;
      end
    end
  end

  // D path: fields are broadcast, only the addressed channel sees valid.
  assign o_sd_opcode  = {NoC{i_m_d_opcode}};
  assign o_sd_param   = {NoC{i_m_d_param}};
  assign o_sd_size    = {NoC{i_m_d_size}};
  assign o_sd_data    = {NoC{i_m_d_data}};
  assign o_sd_denied  = {NoC{i_m_d_denied}};
  assign o_sd_corrupt = {NoC{i_m_d_corrupt}};

  assign w_d_hit = int'(i_m_d_source) < NoC;

  // Out-of-range sources are accepted and dropped so the interconnect never
  // stalls on a response nobody owns.
  always_comb begin
    o_sd_valid      = '0;
    w_m_d_ready_raw = 1'b1;
    for (int i = 0; i < NoC; i++) begin
      if (w_d_hit && (int'(i_m_d_source) == i)) begin
        o_sd_valid[i]   = i_m_d_valid && !i_dma_reset;
        w_m_d_ready_raw = i_sd_ready[i];
      end
    end
  end

  assign o_m_d_ready = !i_dma_reset && w_m_d_ready_raw;
  assign o_bad_src   = !i_dma_reset && i_m_d_valid && !w_d_hit;
  assign w_d_hs      = i_m_d_valid && o_m_d_ready && w_d_hit;

  always_ff @(posedge i_dma_clock) begin
    if (i_dma_reset) begin
      r_rr_ptr   <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_a_hs) begin
      r_rr_ptr <= w_rr_next;
      r_lock   <= 1'b0;
    end else if (o_m_a_valid) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_grant;
    end
  end

  // An issue and a retire on the same channel in one cycle cancel out.
  always_ff @(posedge i_dma_clock) begin
    for (int i = 0; i < NoC; i++) begin
      if (i_dma_reset) begin
        r_out_cnt[i] <= '0;
      end else begin
        if (w_a_hs && (int'(w_grant) == i) &&
            !(w_d_hs && (int'(i_m_d_source) == i))) begin
          r_out_cnt[i] <= r_out_cnt[i] + 4'd1;
        end else if (w_d_hs && (int'(i_m_d_source) == i) &&
                     !(w_a_hs && (int'(w_grant) == i)) &&
                     (r_out_cnt[i] != 4'd0)) begin
          r_out_cnt[i] <= r_out_cnt[i] - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tl_dma_master_arbiter.sv
// tb/tb_tl_dma_master_arbiter.sv - scoreboard bench for tl_dma_master_arbiter

module tb_tl_dma_master_arbiter;

  localparam int NOC = 2;
  localparam int RS  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [3*NOC-1:0]  sa_opcode, sa_param;
  logic [4*NOC-1:0]  sa_size, sa_mask;
  logic [32*NOC-1:0] sa_address, sa_data;
  logic [NOC-1:0]    sa_corrupt, sa_valid, sa_ready;
  logic [3*NOC-1:0]  sd_opcode;
  logic [2*NOC-1:0]  sd_param;
  logic [4*NOC-1:0]  sd_size;
  logic [32*NOC-1:0] sd_data;
  logic [NOC-1:0]    sd_denied, sd_corrupt, sd_valid, sd_ready;
  logic [2:0]        m_a_opcode, m_a_param;
  logic [3:0]        m_a_size, m_a_mask;
  logic [RS-1:0]     m_a_source;
  logic [31:0]       m_a_address, m_a_data;
  logic              m_a_corrupt, m_a_valid, m_a_ready;
  logic [2:0]        m_d_opcode;
  logic [1:0]        m_d_param;
  logic [3:0]        m_d_size;
  logic [RS-1:0]     m_d_source;
  logic [31:0]       m_d_data;
  logic              m_d_denied, m_d_corrupt, m_d_valid, m_d_ready;
  logic              bad_src;

  typedef struct {
    logic [RS-1:0] src;
    logic [31:0]   addr;
    logic [31:0]   data;
  } a_exp_t;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } d_exp_t;

  a_exp_t a_q[$];
  d_exp_t d_q[$];
  a_exp_t ea;
  d_exp_t ed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tl_dma_master_arbiter #(.NoC(NOC), .TL_RS(RS), .MAX_OUT(1)) dut (
    .i_dma_clock   (clk),
    .i_dma_reset   (rst),
    .i_sa_opcode   (sa_opcode),
    .i_sa_param    (sa_param),
    .i_sa_size     (sa_size),
    .i_sa_address  (sa_address),
    .i_sa_data     (sa_data),
    .i_sa_mask     (sa_mask),
    .i_sa_corrupt  (sa_corrupt),
    .i_sa_valid    (sa_valid),
    .o_sa_ready    (sa_ready),
    .o_sd_opcode   (sd_opcode),
    .o_sd_param    (sd_param),
    .o_sd_size     (sd_size),
    .o_sd_data     (sd_data),
    .o_sd_denied   (sd_denied),
    .o_sd_corrupt  (sd_corrupt),
    .o_sd_valid    (sd_valid),
    .i_sd_ready    (sd_ready),
    .o_m_a_opcode  (m_a_opcode),
    .o_m_a_param   (m_a_param),
    .o_m_a_size    (m_a_size),
    .o_m_a_source  (m_a_source),
    .o_m_a_address (m_a_address),
    .o_m_a_data    (m_a_data),
    .o_m_a_mask    (m_a_mask),
    .o_m_a_corrupt (m_a_corrupt),
    .o_m_a_valid   (m_a_valid),
    .i_m_a_ready   (m_a_ready),
    .i_m_d_opcode  (m_d_opcode),
    .i_m_d_param   (m_d_param),
    .i_m_d_size    (m_d_size),
    .i_m_d_source  (m_d_source),
    .i_m_d_data    (m_d_data),
    .i_m_d_denied  (m_d_denied),
    .i_m_d_corrupt (m_d_corrupt),
    .i_m_d_valid   (m_d_valid),
    .o_m_d_ready   (m_d_ready),
    .o_bad_src     (bad_src)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int ch, input logic v, input logic [31:0] addr);
    sa_valid[ch]            = v;
    sa_address[32*ch +: 32] = addr;
    sa_data[32*ch +: 32]    = addr ^ 32'h5A5A_0000;
    sa_opcode[3*ch +: 3]    = 3'd4;
    sa_param[3*ch +: 3]     = 3'd0;
    sa_size[4*ch +: 4]      = 4'd2;
    sa_mask[4*ch +: 4]      = 4'hF;
    sa_corrupt[ch]          = 1'b0;
  endtask

  task automatic set_d(input logic v, input logic [RS-1:0] src, input logic [31:0] data);
    m_d_valid  = v;
    m_d_source = src;
    m_d_data   = data;
  endtask

  task automatic push_a(input int src, input logic [31:0] addr);
    a_exp_t e;
    e.src  = RS'(src);
    e.addr = addr;
    e.data = addr ^ 32'h5A5A_0000;
    a_q.push_back(e);
  endtask

  task automatic push_d(input int ch, input logic [31:0] data);
    d_exp_t e;
    e.ch   = ch;
    e.data = data;
    d_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_m_a_valid"}, 64'(m_a_valid), 64'd0);
    check_eq({pfx, "_sa_ready"},  64'(sa_ready),  64'd0);
    check_eq({pfx, "_sd_valid"},  64'(sd_valid),  64'd0);
    check_eq({pfx, "_m_d_ready"}, 64'(m_d_ready), 64'd0);
    check_eq({pfx, "_bad_src"},   64'(bad_src),   64'd0);
  endtask

  // Scoreboard: every accepted beat on either side must match the head of
  // the queue filled when the stimulus was driven.
  always @(negedge clk) begin
    if (m_a_valid && m_a_ready) begin
      if (a_q.size() == 0) begin
        check_eq("a_extra_beat", 64'd1, 64'd0);
      end else begin
        ea = a_q.pop_front();
        check_eq("a_source",  64'(m_a_source),  64'(ea.src));
        check_eq("a_address", 64'(m_a_address), 64'(ea.addr));
        check_eq("a_data",    64'(m_a_data),    64'(ea.data));
      end
    end
    for (int i = 0; i < NOC; i++) begin
      if (sd_valid[i] && sd_ready[i]) begin
        if (d_q.size() == 0) begin
          check_eq("d_extra_beat", 64'd1, 64'd0);
        end else begin
          ed = d_q.pop_front();
          check_eq("d_channel", 64'(i), 64'(ed.ch));
          check_eq("d_data", 64'(sd_data[32*i +: 32]), 64'(ed.data));
        end
      end
    end
  end

  initial begin
    sa_opcode = '0; sa_param = '0; sa_size = '0; sa_mask = '0;
    sa_address = '0; sa_data = '0; sa_corrupt = '0; sa_valid = '0;
    m_d_opcode = 3'd1; m_d_param = '0; m_d_size = 4'd2;
    m_d_denied = 1'b0; m_d_corrupt = 1'b0;

    // Reset with every input active: outputs must still be forced low.
    rst = 1'b1;
    set_a(0, 1'b1, 32'h0000_1000);
    set_a(1, 1'b1, 32'h0000_2000);
    m_a_ready = 1'b1;
    set_d(1'b1, 4'd3, 32'h0);
    sd_ready = '1;
    tick(); #2;
    check_reset_outputs("rst");
    tick();
    rst = 1'b0;
    sa_valid = '0;
    set_d(1'b0, 4'd0, 32'h0);
    #2;
    check_eq("idle_m_a_valid", 64'(m_a_valid), 64'd0);

    // Both channels always requesting, responses one cycle later.
    for (int k = 0; k < 6; k++) begin
      tick();
      set_a(0, 1'b1, 32'h1000 + 32'(4 * k));
      set_a(1, 1'b1, 32'h2000 + 32'(4 * k));
      m_a_ready = 1'b1;
      push_a(k % 2, ((k % 2) == 1) ? 32'h2000 + 32'(4 * k) : 32'h1000 + 32'(4 * k));
      if (k > 0) begin
        set_d(1'b1, RS'((k - 1) % 2), 32'hD000_0000 + 32'(k));
        push_d((k - 1) % 2, 32'hD000_0000 + 32'(k));
      end else begin
        set_d(1'b0, 4'd0, 32'h0);
      end
      #2;
      check_eq("rr_source", 64'(m_a_source), 64'(k % 2));
      check_eq("rr_sa_ready", 64'(sa_ready), ((k % 2) == 1) ? 64'd2 : 64'd1);
    end
    tick();
    sa_valid = '0;
    set_d(1'b1, 4'd1, 32'hD000_0006);
    push_d(1, 32'hD000_0006);

    // Move the round-robin pointer to channel 1.
    tick();
    set_a(0, 1'b1, 32'h1000);
    set_d(1'b0, 4'd0, 32'h0);
    push_a(0, 32'h1000);
    tick();
    sa_valid = '0;
    set_d(1'b1, 4'd0, 32'hD000_00D1);
    push_d(0, 32'hD000_00D1);

    // Stalled ch0 request must stay presented although ch1 would now win.
    for (int s = 0; s < 4; s++) begin
      tick();
      set_a(0, 1'b1, 32'h1000);
      set_a(1, s >= 1, 32'h2000);
      m_a_ready = (s == 3);
      set_d(1'b0, 4'd0, 32'h0);
      if (s == 3) push_a(0, 32'h1000);
      #2;
      check_eq("lock_address", 64'(m_a_address), 64'h1000);
      check_eq("lock_source", 64'(m_a_source), 64'd0);
      if (s < 3) check_eq("lock_sa_ready", 64'(sa_ready), 64'd0);
    end
    tick();
    set_a(0, 1'b0, 32'h0);
    set_a(1, 1'b1, 32'h2000);
    m_a_ready = 1'b1;
    set_d(1'b1, 4'd0, 32'hD000_00D2);
    push_d(0, 32'hD000_00D2);
    push_a(1, 32'h2000);
    #2;
    check_eq("after_lock_source", 64'(m_a_source), 64'd1);
    tick();
    sa_valid = '0;
    set_d(1'b1, 4'd1, 32'hD000_00D3);
    push_d(1, 32'hD000_00D3);

    // Outstanding limit.
    tick();
    set_a(0, 1'b1, 32'h1100);
    set_a(1, 1'b0, 32'h0);
    set_d(1'b0, 4'd0, 32'h0);
    push_a(0, 32'h1100);
    tick();
    set_a(0, 1'b1, 32'h1104);
    set_a(1, 1'b1, 32'h2100);
    push_a(1, 32'h2100);
    #2;
    check_eq("limit_ch1_served", 64'(m_a_source), 64'd1);
    tick();
    set_d(1'b1, 4'd0, 32'hD000_00D4);
    push_d(0, 32'hD000_00D4);
    #2;
    check_eq("limit_blocked_valid", 64'(m_a_valid), 64'd0);
    check_eq("limit_blocked_ready", 64'(sa_ready), 64'd0);
    tick();
    set_d(1'b0, 4'd0, 32'h0);
    push_a(0, 32'h1104);
    #2;
    check_eq("limit_ch0_again", 64'(m_a_source), 64'd0);
    tick();
    sa_valid = '0;
    set_d(1'b1, 4'd0, 32'hD000_00D5);
    push_d(0, 32'hD000_00D5);
    tick();
    set_d(1'b1, 4'd1, 32'hD000_00D6);
    push_d(1, 32'hD000_00D6);

    // Out-of-range response source.
    tick();
    set_d(1'b1, 4'd3, 32'h0000_0BAD);
    sd_ready = '0;
    #2;
    check_eq("bad_m_d_ready", 64'(m_d_ready), 64'd1);
    check_eq("bad_src_pulse", 64'(bad_src), 64'd1);
    check_eq("bad_sd_valid", 64'(sd_valid), 64'd0);

    // Back-pressured response held until the channel accepts it.
    for (int c = 0; c < 3; c++) begin
      tick();
      set_d(1'b1, 4'd1, 32'hDEAD_BEEF);
      sd_ready = (c == 2) ? 2'b11 : 2'b01;
      if (c == 2) push_d(1, 32'hDEAD_BEEF);
      #2;
      check_eq("bp_m_d_ready", 64'(m_d_ready), (c == 2) ? 64'd1 : 64'd0);
      check_eq("bp_sd_valid", 64'(sd_valid), 64'd2);
      check_eq("bp_sd_data", 64'(sd_data[63:32]), 64'hDEAD_BEEF);
      check_eq("bp_sd_opcode", 64'(sd_opcode[5:3]), 64'd1);
      check_eq("bp_bad_src", 64'(bad_src), 64'd0);
    end

    // Reset while locked on ch0 with ch1 outstanding.
    tick();
    set_d(1'b0, 4'd0, 32'h0);
    sd_ready = '1;
    set_a(0, 1'b0, 32'h0);
    set_a(1, 1'b1, 32'h2200);
    m_a_ready = 1'b1;
    push_a(1, 32'h2200);
    tick();
    set_a(1, 1'b0, 32'h0);
    set_a(0, 1'b1, 32'h1200);
    m_a_ready = 1'b0;
    #2;
    check_eq("pre_rst_valid", 64'(m_a_valid), 64'd1);
    check_eq("pre_rst_source", 64'(m_a_source), 64'd0);
    tick();
    rst = 1'b1;
    set_a(1, 1'b1, 32'h2204);
    set_d(1'b1, 4'd3, 32'h0000_0BAD);
    #2;
    check_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    set_a(0, 1'b0, 32'h0);
    set_a(1, 1'b0, 32'h0);
    set_d(1'b1, 4'd1, 32'hD000_00D7);
    push_d(1, 32'hD000_00D7);
    #2;
    check_eq("post_rst_unlocked", 64'(m_a_valid), 64'd0);
    check_eq("post_rst_stray_d", 64'(sd_valid), 64'd2);
    tick();
    set_d(1'b0, 4'd0, 32'h0);
    set_a(1, 1'b1, 32'h2208);
    m_a_ready = 1'b1;
    push_a(1, 32'h2208);
    #2;
    check_eq("post_rst_ch1_valid", 64'(m_a_valid), 64'd1);
    check_eq("post_rst_ch1_source", 64'(m_a_source), 64'd1);

    // Issue and retire on ch1 in the same cycle leaves its count at zero.
    tick();
    set_a(1, 1'b0, 32'h0);
    set_d(1'b1, 4'd1, 32'hD000_00D8);
    push_d(1, 32'hD000_00D8);
    tick();
    set_a(1, 1'b1, 32'h220C);
    set_d(1'b1, 4'd1, 32'hD000_00D9);
    push_d(1, 32'hD000_00D9);
    push_a(1, 32'h220C);
    tick();
    set_a(1, 1'b1, 32'h2210);
    set_d(1'b0, 4'd0, 32'h0);
    push_a(1, 32'h2210);
    #2;
    check_eq("same_cycle_ch1_eligible", 64'(m_a_valid), 64'd1);
    tick();
    sa_valid = '0;
    m_a_ready = 1'b0;
    set_d(1'b1, 4'd1, 32'hD000_00DA);
    push_d(1, 32'hD000_00DA);
    tick();
    set_d(1'b0, 4'd0, 32'h0);
    tick();

    check_eq("a_queue_empty", 64'(a_q.size()), 64'd0);
    check_eq("d_queue_empty", 64'(d_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
